strobe_enable_gen: RTL and testbench



---
 rtl/strobe_enable_gen.sv | 135 +++++++++++++
 tb/tb_strobe_enable_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/strobe_enable_gen.sv
// strobe_enable_gen: programmable-rate one-cycle enable strobe plus serial
// pattern bit for a downstream enable-gated DFF. RUN strobes continuously,
// ONE issues a single strobe, stop aborts either back to IDLE.
module strobe_enable_gen #(
    parameter int CNT_W       = 8,
    parameter int PAT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             oneshot,
    input  logic             stop,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_in,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             en,
    output logic             d_out,
    output logic             busy,
    output logic [7:0]       strobe_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_nxt;
    logic [CNT_W-1:0] divisor;
    logic [CNT_W-1:0] div_eff;
    logic [PAT_W-1:0] pattern;
    logic             en_nxt;
    logic             launch;
    logic             hit;

    // A divisor of zero behaves like one: a strobe on every edge.
    assign div_eff = (divisor == '0) ? CNT_W'(1) : divisor;
    assign hit     = (counter == div_eff - CNT_W'(1));
    assign d_out   = pattern[PAT_W-1];

    // Next-state, next-counter and strobe decision.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        en_nxt      = 1'b0;
        launch      = 1'b0;
        unique case (state)
            IDLE: begin
                counter_nxt = '0;
                if (start) begin
                    state_nxt = RUN;
                    launch    = 1'b1;
                end else if (oneshot) begin
                    state_nxt = ONE;
                    launch    = 1'b1;
                end
            end
            RUN, ONE: begin
                if (stop) begin
                    // stop beats a strobe due on this same edge
                    state_nxt   = IDLE;
                    counter_nxt = '0;
                end else if (hit) begin
                    counter_nxt = '0;
                    en_nxt      = 1'b1;
                    if (state == ONE) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    counter_nxt = counter + CNT_W'(1);
                end
            end
            default: begin
                state_nxt   = IDLE;
                counter_nxt = '0;
            end
        endcase
    end

    // State, divide counter, strobe and busy registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            counter <= '0;
            en      <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
            en      <= en_nxt;
            busy    <= (state_nxt != IDLE);
        end
    end

    // Divisor is only writable while idle; the loaded value governs the next run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor <= CNT_W'(DEFAULT_DIV);
        end else if (state == IDLE && div_load) begin
            divisor <= div_in;
        end
    end

    // Pattern loads while idle, otherwise rotates left once per completed strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern <= '0;
        end else if (state == IDLE && pat_load) begin
            pattern <= pat_in;
        end else if (en) begin
            pattern <= {pattern[PAT_W-2:0], pattern[PAT_W-1]};
        end
    end

    // Strobe counter clears on launch and counts each completed strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_cnt <= '0;
        end else if (launch) begin
            strobe_cnt <= '0;
        end else if (en) begin
            strobe_cnt <= strobe_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_strobe_enable_gen.sv
// Self-checking bench for strobe_enable_gen: a cycle-level reference model
// checked on every falling edge, plus directed scenarios with literal values.
module tb_strobe_enable_gen;

    localparam int CNT_W = 8;
    localparam int PAT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             oneshot = 1'b0;
    logic             stop = 1'b0;
    logic             div_load = 1'b0;
    logic [CNT_W-1:0] div_in = '0;
    logic             pat_load = 1'b0;
    logic [PAT_W-1:0] pat_in = '0;
    logic             en;
    logic             d_out;
    logic             busy;
    logic [7:0]       strobe_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    strobe_enable_gen #(.CNT_W(CNT_W), .PAT_W(PAT_W), .DEFAULT_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .oneshot    (oneshot),
        .stop       (stop),
        .div_load   (div_load),
        .div_in     (div_in),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
        .en         (en),
        .d_out      (d_out),
        .busy       (busy),
        .strobe_cnt (strobe_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    // Reference model: mode 0=idle 1=run 2=one; k = edges since launch,
    // ptr = rotations applied to the loaded pattern.
    int   m_mode = 0;
    int   m_k    = 0;
    int   m_div  = 4;
    int   m_ptr  = 0;
    int   m_cnt  = 0;
    bit   m_en   = 0;
    logic [PAT_W-1:0] m_pat = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_k = 0; m_div = 4; m_ptr = 0; m_cnt = 0; m_en = 0; m_pat = '0;
        end else begin
            automatic bit old_en = m_en;
            automatic int deff   = (m_div == 0) ? 1 : m_div;
            if (m_mode == 0) begin
                m_en = 0;
                if (div_load) m_div = int'(div_in);
                if (pat_load) begin m_pat = pat_in; m_ptr = 0; end
                else if (old_en) m_ptr = (m_ptr + 1) % PAT_W;
                if (start || oneshot) begin
                    m_mode = start ? 1 : 2;
                    m_k = 0;
                    m_cnt = 0;
                end else if (old_en) m_cnt = (m_cnt + 1) % 256;
            end else begin
                if (old_en) begin
                    m_ptr = (m_ptr + 1) % PAT_W;
                    m_cnt = (m_cnt + 1) % 256;
                end
                if (stop) begin
                    m_mode = 0;
                    m_en = 0;
                end else begin
                    m_k++;
                    m_en = (m_k % deff == 0);
                    if (m_en && m_mode == 2) m_mode = 0;
                end
            end
        end
    end

    // Compare DUT with model every cycle, away from the rising edge.
    always @(negedge clk) begin
        check("model_en",   int'(en),         int'(m_en));
        check("model_busy", int'(busy),       int'(m_mode != 0));
        check("model_dout", int'(d_out),      int'(m_pat[PAT_W-1-m_ptr]));
        check("model_cnt",  int'(strobe_cnt), m_cnt);
    end

    // One full clock: the rising edge, then settle at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input int dv, input bit do_div, input int pv, input bit do_pat);
        div_load = do_div; div_in = CNT_W'(dv);
        pat_load = do_pat; pat_in = PAT_W'(pv);
        tick();
        div_load = 0; pat_load = 0;
    endtask

    task automatic do_stop();
        stop = 1; tick(); stop = 0;
    endtask

    initial begin
        // 1. Reset values and quiet idle
        #1;
        check("rst_en", int'(en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_dout", int'(d_out), 0);
        check("rst_cnt", int'(strobe_cnt), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("idle_en", int'(en), 0);
        end

        // 2. Continuous, default divisor 4, pattern A5
        load(0, 0, 'hA5, 1);
        start = 1; tick(); start = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            check("run4_en", int'(en), int'(c % 4 == 0));
            if (c % 4 == 0) check("run4_dout", int'(d_out), int'((c / 4) % 2 == 1));
        end
        tick();
        check("run4_cnt", int'(strobe_cnt), 4);
        do_stop();
        check("run4_stop_busy", int'(busy), 0);

        // 3. Oneshot with divisor 2
        load(2, 1, 0, 0);
        oneshot = 1; tick(); oneshot = 0;
        check("one_busy0", int'(busy), 1);
        tick();
        check("one_en1", int'(en), 0);
        check("one_busy1", int'(busy), 1);
        tick();
        check("one_en2", int'(en), 1);
        check("one_busy2", int'(busy), 0);
        for (int c = 0; c < 20; c++) begin
            tick();
            check("one_quiet_en", int'(en), 0);
        end
        check("one_cnt", int'(strobe_cnt), 1);

        // 4. Stop colliding with the second strobe, divisor 3
        load(3, 1, 0, 0);
        start = 1; tick(); start = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check("stop_en", int'(en), int'(c == 3));
        end
        do_stop();
        check("stop_en6", int'(en), 0);
        check("stop_busy", int'(busy), 0);
        check("stop_cnt", int'(strobe_cnt), 1);
        tick();
        check("stop_idle_en", int'(en), 0);

        // 5. Divisor 0 strobes every cycle; loads while busy are ignored
        load(0, 1, 'h80, 1);
        start = 1; tick(); start = 0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 2) begin
                div_load = 1; div_in = 9; pat_load = 1; pat_in = 'hFF;
            end
            tick();
            div_load = 0; pat_load = 0;
            check("div0_en", int'(en), 1);
            check("div0_dout", int'(d_out), int'(c == 1 || c == 9));
        end
        do_stop();
        check("div0_cnt", int'(strobe_cnt), 9);

        // 6. Async reset during a strobe cycle
        load(4, 1, 'hC3, 1);
        start = 1; tick(); start = 0;
        for (int c = 1; c <= 8; c++) tick();
        check("pre_rst_en", int'(en), 1);
        check("pre_rst_cnt", int'(strobe_cnt), 1);
        #2 rst_n = 0;
        #1;
        check("arst_en", int'(en), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_cnt", int'(strobe_cnt), 0);
        check("arst_dout", int'(d_out), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("post_rst_en", int'(en), 0);
        end
        start = 1; tick(); start = 0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("restart_en", int'(en), int'(c == 4));
        end
        do_stop();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
